tick_gen: RTL and testbench

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_gen.sv | 160 ++++++++++++++++
 tb/tb_tick_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Per-channel programmable clock-enable / square-wave generator with glitch-free ratio updates.
// Latency: tick and wave are registered, one cycle behind the counter state that produces them.
// Backpressure: cfg_ready drops while any channel holds an unapplied update; requests are refused until it lands.
// Optional feature: define TICK_GEN_PHASE_ALIGN_EN to let sync zero all enabled counters at once.
module tick_gen #(
    parameter int              NCH       = 2,
    parameter int              CW        = 32,
    parameter logic [CW-1:0]   DIV_RESET = CW'(1000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CW-1:0]     cfg_div,
    input  logic [CW-1:0]     cfg_duty,
    input  logic              sync,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    wave
);

    localparam logic [CW-1:0] DUTY_RESET = DIV_RESET >> 1;
    localparam logic [CW-1:0] ONE        = {{(CW-1){1'b0}}, 1'b1};

    // Live counter and active ratio per channel
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [CW-1:0]  div_q   [NCH];
    logic [CW-1:0]  div_d   [NCH];
    logic [CW-1:0]  duty_q  [NCH];
    logic [CW-1:0]  duty_d  [NCH];

    // Pending slot: holds an accepted update until the channel reaches a safe point
    logic [CW-1:0]  pdiv_q  [NCH];
    logic [CW-1:0]  pdiv_d  [NCH];
    logic [CW-1:0]  pduty_q [NCH];
    logic [CW-1:0]  pduty_d [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;

    // Registered outputs
    logic [NCH-1:0] tick_q;
    logic [NCH-1:0] tick_d;
    logic [NCH-1:0] wave_q;
    logic [NCH-1:0] wave_d;
    logic           cfg_ready_q;
    logic           cfg_ready_d;

    logic           cfg_acc;
    logic           sync_hit;

`ifdef TICK_GEN_PHASE_ALIGN_EN
    assign sync_hit = sync;
`else
    // Without phase alignment the strobe has no effect; channels drift independently.
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_hit    = 1'b0;
`endif

    // A request is taken only while ready; out-of-range channels match no slot and vanish.
    always_comb begin
        cfg_acc = cfg_valid && cfg_ready_q;
    end

    // Per-channel next state: count, wrap, swap in pending ratio at a period boundary, capture new config.
    always_comb begin
        logic [CW-1:0] div_eff;
        logic          last;
        logic          sel;
        logic          apply;
        div_eff = ONE;
        last    = 1'b0;
        sel     = 1'b0;
        apply   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            // A zero ratio behaves as one: the channel wraps every cycle.
            div_eff = (div_q[i] == '0) ? ONE : div_q[i];
            last    = (cnt_q[i] == (div_eff - ONE));
            sel     = cfg_acc && (cfg_ch == 3'(i));
            apply   = 1'b0;

            cnt_d[i]   = cnt_q[i];
            div_d[i]   = div_q[i];
            duty_d[i]  = duty_q[i];
            pdiv_d[i]  = pdiv_q[i];
            pduty_d[i] = pduty_q[i];
            pend_d[i]  = pend_q[i];
            tick_d[i]  = 1'b0;
            wave_d[i]  = 1'b0;

            if (!en[i]) begin
                // Idle channel parks at zero, so a pending update can land right away.
                cnt_d[i] = '0;
                apply    = pend_q[i];
            end else if (sync_hit) begin
                // Phase align: restart from zero, no tick, treat as a boundary for updates.
                cnt_d[i]  = '0;
                wave_d[i] = (cnt_q[i] < duty_q[i]);
                apply     = pend_q[i];
            end else begin
                cnt_d[i]  = last ? '0 : (cnt_q[i] + ONE);
                tick_d[i] = last;
                wave_d[i] = (cnt_q[i] < duty_q[i]);
                apply     = last && pend_q[i];
            end

            if (apply) begin
                div_d[i]  = pdiv_q[i];
                duty_d[i] = pduty_q[i];
                pend_d[i] = 1'b0;
            end

            // Capture uses the registered pend, so an update taken on a wrap cycle
            // waits for the following wrap. Accept and apply never coincide because
            // accept requires every pend bit to be clear.
            if (sel) begin
                pend_d[i]  = 1'b1;
                pdiv_d[i]  = cfg_div;
                pduty_d[i] = cfg_duty;
            end
        end
        cfg_ready_d = ~|pend_d;
    end

    // State registers with synchronous reset; reset drops any pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= DIV_RESET;
                duty_q[i]  <= DUTY_RESET;
                pdiv_q[i]  <= '0;
                pduty_q[i] <= '0;
            end
            pend_q      <= '0;
            tick_q      <= '0;
            wave_q      <= '0;
            cfg_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                duty_q[i]  <= duty_d[i];
                pdiv_q[i]  <= pdiv_d[i];
                pduty_q[i] <= pduty_d[i];
            end
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            wave_q      <= wave_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign tick      = tick_q;
    assign wave      = wave_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: stimulus phases push expected tick cycles and sampled values,
// a negedge monitor pops and compares them against what the DUT presents.
// Cycle n means the window between posedge n and posedge n+1.
module tb_tick_gen;

    localparam int END    = 4250;
    localparam int K_WAVE = 0;
    localparam int K_RDY  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [31:0] cfg_div;
    logic [31:0] cfg_duty;
    logic        sync;
    logic [1:0]  tick;
    logic [1:0]  wave;

    typedef struct {
        int   cyc;
        int   kind;
        int   idx;
        logic val;
    } samp_t;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    tq [2][$];
    samp_t sq [$];

    tick_gen #(.NCH(2), .CW(32), .DIV_RESET(32'd1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_duty  (cfg_duty),
        .sync      (sync),
        .tick      (tick),
        .wave      (wave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ticks(input int ch, input int first, input int step, input int last);
        for (int c = first; c <= last; c += step) tq[ch].push_back(c);
    endtask

    task automatic expect_at(input int c, input int kind, input int idx, input logic v);
        samp_t s;
        s.cyc = c; s.kind = kind; s.idx = idx; s.val = v;
        sq.push_back(s);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request held for one cycle; accepted on the following edge when ready.
    task automatic cfg(input int ch, input logic [31:0] d, input logic [31:0] du);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = d;
        cfg_duty  = du;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic chk_tick(input int ch, input logic t);
        while (tq[ch].size() > 0 && tq[ch][0] < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick%0d missed: got no pulse, want pulse at cycle %0d", ch, tq[ch][0]);
            void'(tq[ch].pop_front());
        end
        if (t) begin
            n_chk++;
            if (tq[ch].size() > 0 && tq[ch][0] == cyc) begin
                void'(tq[ch].pop_front());
            end else begin
                n_fail++;
                $display("FAIL tick%0d unexpected: got pulse at cycle %0d, want none", ch, cyc);
            end
        end
    endtask

    // Monitor: every tick must be expected; timestamped samples are compared when due.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= END) begin
            chk_tick(0, tick[0]);
            chk_tick(1, tick[1]);
            for (int k = sq.size() - 1; k >= 0; k--) begin
                if (sq[k].cyc == cyc) begin
                    logic act;
                    act = (sq[k].kind == K_WAVE) ? wave[sq[k].idx] : cfg_ready;
                    n_chk++;
                    if (act !== sq[k].val) begin
                        n_fail++;
                        $display("FAIL %s%0d cycle %0d: got %b want %b",
                                 (sq[k].kind == K_WAVE) ? "wave" : "cfg_ready",
                                 sq[k].idx, cyc, act, sq[k].val);
                    end
                    sq.delete(k);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 2'b01; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_div = '0; cfg_duty = '0; sync = 1'b0;

        // Reset defaults: ratio 1000, duty 500, channel 1 idle
        push_ticks(0, 1003, 1000, 2003);
        expect_at(2, K_WAVE, 0, 1'b0); expect_at(2, K_WAVE, 1, 1'b0); expect_at(2, K_RDY, 0, 1'b1);
        expect_at(4, K_WAVE, 0, 1'b1); expect_at(503, K_WAVE, 0, 1'b1);
        expect_at(504, K_WAVE, 0, 1'b0); expect_at(1003, K_WAVE, 0, 1'b0);
        expect_at(1004, K_WAVE, 0, 1'b1); expect_at(1500, K_WAVE, 1, 1'b0);
        at(3);
        rst = 1'b0;

        // Mid-period reconfig to 10/3: current period completes first
        at(1500);
        push_ticks(0, 2013, 10, 2043);
        expect_at(1501, K_RDY, 0, 1'b0); expect_at(2002, K_RDY, 0, 1'b0); expect_at(2003, K_RDY, 0, 1'b1);
        expect_at(2004, K_WAVE, 0, 1'b1); expect_at(2006, K_WAVE, 0, 1'b1);
        expect_at(2007, K_WAVE, 0, 1'b0); expect_at(2013, K_WAVE, 0, 1'b0);
        expect_at(2014, K_WAVE, 0, 1'b1);
        cfg(0, 32'd10, 32'd3);

        // div=0 acts as 1, duty=0 keeps wave low
        at(2050);
        push_ticks(0, 2053, 1, 2062);
        expect_at(2052, K_RDY, 0, 1'b0); expect_at(2053, K_RDY, 0, 1'b1);
        expect_at(2055, K_WAVE, 0, 1'b0); expect_at(2060, K_WAVE, 0, 1'b0);
        cfg(0, 32'd0, 32'd0);

        // duty beyond div keeps wave high
        at(2060);
        push_ticks(0, 2072, 10, 2122);
        expect_at(2063, K_WAVE, 0, 1'b1); expect_at(2072, K_WAVE, 0, 1'b1);
        expect_at(2080, K_WAVE, 0, 1'b1);
        cfg(0, 32'd10, 32'd20);

        // duty=0 with div=10
        at(2085);
        expect_at(2092, K_WAVE, 0, 1'b1); expect_at(2093, K_WAVE, 0, 1'b0);
        expect_at(2101, K_WAVE, 0, 1'b0);
        cfg(0, 32'd10, 32'd0);

        // Config accepted on the wrap edge waits a full extra period
        at(2111);
        push_ticks(0, 2126, 4, 2150);
        expect_at(2112, K_RDY, 0, 1'b0); expect_at(2121, K_RDY, 0, 1'b0); expect_at(2122, K_RDY, 0, 1'b1);
        expect_at(2123, K_WAVE, 0, 1'b1); expect_at(2124, K_WAVE, 0, 1'b1);
        expect_at(2125, K_WAVE, 0, 1'b0); expect_at(2126, K_WAVE, 0, 1'b0);
        expect_at(2127, K_WAVE, 0, 1'b1);
        cfg(0, 32'd4, 32'd2);

        // Out-of-range channel is swallowed
        at(2140);
        expect_at(2141, K_RDY, 0, 1'b1); expect_at(2142, K_RDY, 0, 1'b1);
        cfg(5, 32'd3, 32'd1);

        // Reset with an update pending: defaults come back, update is lost
        at(2151);
        push_ticks(0, 3155, 1000, 4155);
        expect_at(2152, K_RDY, 0, 1'b0); expect_at(2153, K_RDY, 0, 1'b1);
        expect_at(2154, K_WAVE, 0, 1'b0); expect_at(2154, K_WAVE, 1, 1'b0);
        expect_at(2156, K_RDY, 0, 1'b1);
        expect_at(2156, K_WAVE, 0, 1'b1); expect_at(2655, K_WAVE, 0, 1'b1);
        expect_at(2656, K_WAVE, 0, 1'b0); expect_at(3155, K_WAVE, 0, 1'b0);
        expect_at(3156, K_WAVE, 0, 1'b1);
        cfg(0, 32'd7, 32'd1);
        rst = 1'b1;
        at(2155);
        rst = 1'b0;

        // Idle channel takes its update in the cycle after acceptance
        at(3160);
        expect_at(3161, K_RDY, 0, 1'b0); expect_at(3162, K_RDY, 0, 1'b1);
        cfg(1, 32'd15, 32'd5);

        at(3165);
`ifdef TICK_GEN_PHASE_ALIGN_EN
        push_ticks(0, 4165, 10, 4195);
        push_ticks(0, 4211, 10, END);
`else
        push_ticks(0, 4165, 10, END);
`endif
        expect_at(3166, K_RDY, 0, 1'b0); expect_at(4154, K_RDY, 0, 1'b0); expect_at(4155, K_RDY, 0, 1'b1);
        expect_at(4156, K_WAVE, 0, 1'b1); expect_at(4159, K_WAVE, 0, 1'b0);
        cfg(0, 32'd10, 32'd3);

        // Enable / disable / re-enable channel 1
        at(3170);
        push_ticks(1, 3185, 15, 3230);
        expect_at(3171, K_WAVE, 1, 1'b1); expect_at(3175, K_WAVE, 1, 1'b1);
        expect_at(3176, K_WAVE, 1, 1'b0); expect_at(3185, K_WAVE, 1, 1'b0);
        expect_at(3186, K_WAVE, 1, 1'b1);
        en = 2'b11;
        at(3230);
        expect_at(3231, K_WAVE, 1, 1'b0); expect_at(3240, K_WAVE, 1, 1'b0);
        en = 2'b01;
        at(3250);
`ifdef TICK_GEN_PHASE_ALIGN_EN
        push_ticks(1, 3265, 15, 4195);
        push_ticks(1, 4216, 15, END);
`else
        push_ticks(1, 3265, 15, END);
`endif
        expect_at(3251, K_WAVE, 1, 1'b1);
        en = 2'b11;

        // Sync strobe
        at(4200);
        sync = 1'b1;
        at(4201);
        sync = 1'b0;

        at(END + 2);
        for (int ch = 0; ch < 2; ch++) begin
            while (tq[ch].size() > 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL tick%0d missed: got no pulse, want pulse at cycle %0d", ch, tq[ch][0]);
                void'(tq[ch].pop_front());
            end
        end
        while (sq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sample unchecked: got nothing at cycle %0d, want kind %0d value %b",
                     sq[0].cyc, sq[0].kind, sq[0].val);
            void'(sq.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
